result_writeback: RTL and testbench



---
 rtl/result_writeback_if.sv | 33 +++
 rtl/result_writeback.sv | 133 +++++++++++++
 tb/tb_result_writeback.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/result_writeback_if.sv
// Store-path bundle between the control unit (master) and the writeback engine (slave),
// carrying the operation request, the four PE result words and the BRAM port B signals.
interface result_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              WB_START;
    logic [ADDR_W-1:0] BASE_ADDR;
    logic [3:0]        PE_MASK;
    logic              ADDR_MODE;
    logic [DATA_W-1:0] PE_DOUT_0;
    logic [DATA_W-1:0] PE_DOUT_1;
    logic [DATA_W-1:0] PE_DOUT_2;
    logic [DATA_W-1:0] PE_DOUT_3;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dinb;
    logic              enb;
    logic [3:0]        web;
    logic              STORE_BUSY;
    logic              STORE_DONE;

    modport master (
        output WB_START, BASE_ADDR, PE_MASK, ADDR_MODE,
        output PE_DOUT_0, PE_DOUT_1, PE_DOUT_2, PE_DOUT_3,
        input  addrb, dinb, enb, web, STORE_BUSY, STORE_DONE
    );

    modport slave (
        input  WB_START, BASE_ADDR, PE_MASK, ADDR_MODE,
        input  PE_DOUT_0, PE_DOUT_1, PE_DOUT_2, PE_DOUT_3,
        output addrb, dinb, enb, web, STORE_BUSY, STORE_DONE
    );
endinterface

// File: rtl/result_writeback.sv
// Multi-word STORE engine: snapshots the PE results on start and writes the masked words
// to BRAM port B one per cycle in ascending PE order, then pulses STORE_DONE.
module result_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int NUM_PE = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    result_writeback_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_snap [NUM_PE];
    logic [3:0]        r_mask;
    logic [ADDR_W-1:0] r_base;
    logic              r_mode;
    logic [2:0]        r_wcnt;
    logic [ADDR_W-1:0] r_addrb;
    logic [DATA_W-1:0] r_dinb;
    logic              r_enb;
    logic [3:0]        r_web;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] w_inData [NUM_PE];
    logic [1:0]        w_startIdx;
    logic [1:0]        w_nextIdx;
    logic [ADDR_W-1:0] w_startAddr;
    logic [ADDR_W-1:0] w_nextAddr;

    function automatic logic [1:0] lowIdx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign w_inData[0] = bus.PE_DOUT_0;
    assign w_inData[1] = bus.PE_DOUT_1;
    assign w_inData[2] = bus.PE_DOUT_2;
    assign w_inData[3] = bus.PE_DOUT_3;

    // The first write is prepared on the start edge so every BRAM output comes straight from a flop.
    assign w_startIdx  = lowIdx(bus.PE_MASK);
    assign w_nextIdx   = lowIdx(r_mask);
    assign w_startAddr = bus.ADDR_MODE ? bus.BASE_ADDR + ADDR_W'(w_startIdx) : bus.BASE_ADDR;
    assign w_nextAddr  = r_mode ? r_base + ADDR_W'(w_nextIdx) : r_base + ADDR_W'(r_wcnt);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
            for (int i = 0; i < NUM_PE; i++) r_snap[i] <= '0;
            r_mask  <= '0;
            r_base  <= '0;
            r_mode  <= 1'b0;
            r_wcnt  <= '0;
            r_addrb <= '0;
            r_dinb  <= '0;
            r_enb   <= 1'b0;
            r_web   <= 4'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_addrb <= '0;
                    r_dinb  <= '0;
                    r_enb   <= 1'b0;
                    r_web   <= 4'h0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (bus.WB_START) begin
                        for (int i = 0; i < NUM_PE; i++) r_snap[i] <= w_inData[i];
                        r_base <= bus.BASE_ADDR;
                        r_mode <= bus.ADDR_MODE;
                        r_busy <= 1'b1;
                        if (bus.PE_MASK != 4'h0) begin
                            r_state <= WRITE;
                            r_mask  <= bus.PE_MASK & ~(4'b0001 << w_startIdx);
                            r_wcnt  <= 3'd1;
                            r_addrb <= w_startAddr;
                            r_dinb  <= w_inData[w_startIdx];
                            r_enb   <= 1'b1;
                            r_web   <= 4'hF;
                        end else begin
                            r_state <= DONE;
                            r_mask  <= 4'h0;
                            r_wcnt  <= 3'd0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // r_mask holds the PEs still to be written after the one currently on the port.
                    if (r_mask != 4'h0) begin
                        r_mask  <= r_mask & ~(4'b0001 << w_nextIdx);
                        r_wcnt  <= r_wcnt + 3'd1;
                        r_addrb <= w_nextAddr;
                        r_dinb  <= r_snap[w_nextIdx];
                    end else begin
                        r_state <= DONE;
                        r_addrb <= '0;
                        r_dinb  <= '0;
                        r_enb   <= 1'b0;
                        r_web   <= 4'h0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_enb   <= 1'b0;
                    r_web   <= 4'h0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addrb      = r_addrb;
    assign bus.dinb       = r_dinb;
    assign bus.enb        = r_enb;
    assign bus.web        = r_web;
    assign bus.STORE_BUSY = r_busy;
    assign bus.STORE_DONE = r_done;
endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: expected BRAM writes are queued at start and
// matched against port B activity, alongside a small BRAM model for untouched-word checks.
module tb_result_writeback;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   assertCount;
    int   failCount;
    int   doneCount;
    bit   scrambleOn;
    wr_t  expQ[$];
    logic [31:0] mem [logic [31:0]];

    result_writeback_if #(.DATA_W(32), .ADDR_W(32)) wbIf ();

    result_writeback #(.DATA_W(32), .ADDR_W(32), .NUM_PE(4)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (wbIf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    // Port B monitor: every enabled cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn && wbIf.enb) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 64'(wbIf.addrb), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("wrAddr", 64'(wbIf.addrb), 64'(e.addr));
                checkOutput("wrData", 64'(wbIf.dinb), 64'(e.data));
                checkOutput("wrWeb", 64'(wbIf.web), 64'hF);
                checkOutput("wrCycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (wbIf.STORE_DONE) doneCount++;
        if (scrambleOn) begin
            wbIf.PE_DOUT_0 = $urandom;
            wbIf.PE_DOUT_1 = $urandom;
            wbIf.PE_DOUT_2 = $urandom;
            wbIf.PE_DOUT_3 = $urandom;
        end
    end

    always @(posedge clk) begin
        if (rstn && wbIf.enb && wbIf.web == 4'hF) mem[wbIf.addrb] = wbIf.dinb;
    end

    task automatic applyStimulus(input logic [31:0] base, input logic [3:0] mask, input logic mode,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3, output int t0);
        logic [31:0] d [4];
        int n;
        wr_t e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        @(negedge clk);
        wbIf.BASE_ADDR = base;
        wbIf.PE_MASK   = mask;
        wbIf.ADDR_MODE = mode;
        wbIf.PE_DOUT_0 = d0;
        wbIf.PE_DOUT_1 = d1;
        wbIf.PE_DOUT_2 = d2;
        wbIf.PE_DOUT_3 = d3;
        wbIf.WB_START  = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        wbIf.WB_START = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                e.addr = mode ? base + 32'(i) : base + 32'(n);
                e.data = d[i];
                e.cyc  = t0 + n;
                expQ.push_back(e);
                n++;
            end
        end
    endtask

    // Walks spec cycles t0+1 .. t0+k+1 checking BUSY/DONE, optionally pulsing start at cycle pulseAt.
    task automatic waitDone(input int k, input int pulseAt);
        for (int c = 1; c <= k + 1; c++) begin
            @(negedge clk);
            wbIf.WB_START = (c == pulseAt);
            checkOutput("busy", 64'(wbIf.STORE_BUSY), 64'd1);
            checkOutput("done", 64'(wbIf.STORE_DONE), 64'(c == k + 1));
            if (c == k + 1) checkOutput("enbAtDone", 64'(wbIf.enb), 64'd0);
        end
        @(negedge clk);
        wbIf.WB_START = 1'b0;
        checkOutput("doneAfter", 64'(wbIf.STORE_DONE), 64'd0);
        checkOutput("busyAfter", 64'(wbIf.STORE_BUSY), 64'd0);
        checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        int t0;
        int doneBefore;
        assertCount = 0;
        failCount   = 0;
        doneCount   = 0;
        scrambleOn  = 1'b0;
        wbIf.WB_START  = 1'b0;
        wbIf.BASE_ADDR = '0;
        wbIf.PE_MASK   = '0;
        wbIf.ADDR_MODE = 1'b0;
        wbIf.PE_DOUT_0 = '0;
        wbIf.PE_DOUT_1 = '0;
        wbIf.PE_DOUT_2 = '0;
        wbIf.PE_DOUT_3 = '0;
        rstn = 1'b0;
        #1;
        checkOutput("rstAddrb", 64'(wbIf.addrb), 64'd0);
        checkOutput("rstDinb", 64'(wbIf.dinb), 64'd0);
        checkOutput("rstEnb", 64'(wbIf.enb), 64'd0);
        checkOutput("rstWeb", 64'(wbIf.web), 64'd0);
        checkOutput("rstBusy", 64'(wbIf.STORE_BUSY), 64'd0);
        checkOutput("rstDone", 64'(wbIf.STORE_DONE), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        $display("[TB] full packed store");
        applyStimulus(32'h20, 4'hF, 1'b0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, t0);
        waitDone(4, 0);

        $display("[TB] reset during second write");
        mem.delete();
        applyStimulus(32'h20, 4'hF, 1'b0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, t0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("midRstEnb", 64'(wbIf.enb), 64'd0);
        checkOutput("midRstWeb", 64'(wbIf.web), 64'd0);
        checkOutput("midRstBusy", 64'(wbIf.STORE_BUSY), 64'd0);
        checkOutput("midRstAddrb", 64'(wbIf.addrb), 64'd0);
        expQ.delete();
        @(negedge clk);
        rstn = 1'b1;
        checkOutput("mem20Exists", 64'(mem.exists(32'h20)), 64'd1);
        if (mem.exists(32'h20)) checkOutput("mem20", 64'(mem[32'h20]), 64'hA0);
        checkOutput("mem21Untouched", 64'(mem.exists(32'h21)), 64'd0);
        checkOutput("mem22Untouched", 64'(mem.exists(32'h22)), 64'd0);
        checkOutput("mem23Untouched", 64'(mem.exists(32'h23)), 64'd0);
        applyStimulus(32'h20, 4'hF, 1'b0, 32'hB0, 32'hB1, 32'hB2, 32'hB3, t0);
        waitDone(4, 0);

        $display("[TB] packed vs slotted");
        applyStimulus(32'h10, 4'b1010, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, t0);
        waitDone(2, 0);
        mem.delete();
        mem[32'h10] = 32'h5A5A_0010;
        mem[32'h12] = 32'h5A5A_0012;
        applyStimulus(32'h10, 4'b1010, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, t0);
        waitDone(2, 0);
        checkOutput("slot10", 64'(mem[32'h10]), 64'h5A5A_0010);
        checkOutput("slot12", 64'(mem[32'h12]), 64'h5A5A_0012);
        checkOutput("slot11Exists", 64'(mem.exists(32'h11)), 64'd1);
        if (mem.exists(32'h11)) checkOutput("slot11", 64'(mem[32'h11]), 64'd2);
        checkOutput("slot13Exists", 64'(mem.exists(32'h13)), 64'd1);
        if (mem.exists(32'h13)) checkOutput("slot13", 64'(mem[32'h13]), 64'd4);

        $display("[TB] empty mask");
        doneBefore = doneCount;
        applyStimulus(32'h40, 4'h0, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, t0);
        waitDone(0, 0);
        repeat (2) @(negedge clk);
        checkOutput("emptyDoneCount", 64'(doneCount - doneBefore), 64'd1);

        $display("[TB] snapshot and ignored start");
        doneBefore = doneCount;
        applyStimulus(32'h80, 4'hF, 1'b0, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, t0);
        scrambleOn = 1'b1;
        waitDone(4, 2);
        scrambleOn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("snapDoneCount", 64'(doneCount - doneBefore), 64'd1);
        checkOutput("snapIdleEnb", 64'(wbIf.enb), 64'd0);

        $display("[TB] address wrap-around");
        applyStimulus(32'hFFFF_FFFE, 4'hF, 1'b0, 32'hD0, 32'hD1, 32'hD2, 32'hD3, t0);
        waitDone(4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
